// File: rtl/ssd_pkg.sv
// ssd_pkg -- shared types and defaults for the seven-segment scan controller.
//   ssd_state_e    : per-slot FSM state (BLANK gap, then SHOW)
//   digit_idx_t    : 2-bit digit index (0 = least significant nibble)
//   DEF_*          : parameter defaults (1 kHz digit rate at 50 MHz)
//   digit_blanked(): leading-zero blanking rule for one digit
package ssd_pkg;

  localparam int DEF_TICKS_PER_DIGIT = 50000;
  localparam int DEF_BLANK_TICKS     = 500;

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_SHOW  = 1'b1
  } ssd_state_e;

  typedef logic [1:0] digit_idx_t;

  // Digit k (k > 0) is dark when blanking is enabled and it and every more
  // significant nibble are zero. Digit 0 always lights so "0" stays visible.
  function automatic logic digit_blanked(input logic [15:0] disp,
                                         input digit_idx_t  idx,
                                         input logic        blank_lz);
    logic upper_zero;
    upper_zero = 1'b1;
    for (int k = 0; k < 4; k++) begin
      if ((k >= int'(idx)) && (disp[4*k +: 4] != 4'h0)) upper_zero = 1'b0;
    end
    return blank_lz && (idx != 2'd0) && upper_zero;
  endfunction

endpackage

// File: rtl/ssd_scan_controller_if.sv
// ssd_scan_controller_if -- host-side signals of the scan controller.
//   value[15:0], load, blank_lz        : host -> controller
//   select, nibble, digit_en           : controller -> display decoders
//   load_ack, frame_done, dbg_state    : controller -> host / checkers
//
// Handshake: load is a one-cycle strobe with no ready; value is sampled on
// the clock edge where load is high. The controller answers with a one-cycle
// load_ack when a captured value reaches the display. Several loads may map
// onto one load_ack: the last one before the frame boundary wins.
interface ssd_scan_controller_if;
  import ssd_pkg::*;

  logic [15:0] value;
  logic        load;
  logic        blank_lz;
  digit_idx_t  select;
  logic [3:0]  nibble;
  logic        digit_en;
  logic        load_ack;
  logic        frame_done;
  ssd_state_e  dbg_state;

  modport master (
    output value, load, blank_lz,
    input  select, nibble, digit_en, load_ack, frame_done, dbg_state
  );

  modport slave (
    input  value, load, blank_lz,
    output select, nibble, digit_en, load_ack, frame_done, dbg_state
  );

endinterface

// File: rtl/ssd_tick_counter.sv
// ssd_tick_counter -- prescaler for the scan FSM.
//   clk, reset : clock, synchronous active-high reset
//   clear      : restart at 0 on the next edge (state entry)
//   term       : terminal count for the current state
//   tc         : high while count == term (last cycle of the state)
module ssd_tick_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic [W-1:0] term,
  output logic         tc
);

  logic [W-1:0] count;

  assign tc = (count == term);

  always_ff @(posedge clk) begin
    if (reset || clear) count <= '0;
    else                count <= count + 1'b1;
  end

endmodule

// File: rtl/ssd_scan_controller.sv
// ssd_scan_controller -- multiplexed 4-digit hex display scanner.
//   clk, reset : clock, synchronous active-high reset
//   bus        : ssd_scan_controller_if.slave (value/load/blank_lz in;
//                select/nibble/digit_en/load_ack/frame_done/dbg_state out)
// Each digit slot is BLANK for BLANK_TICKS cycles then SHOW for the rest of
// TICKS_PER_DIGIT. Every output is a register, so outputs trail the internal
// state by one cycle; select, nibble and digit_en all trail equally and stay
// aligned with each other.
module ssd_scan_controller
  import ssd_pkg::*;
#(
  parameter int TICKS_PER_DIGIT = DEF_TICKS_PER_DIGIT,
  parameter int BLANK_TICKS     = DEF_BLANK_TICKS
) (
  input  logic                  clk,
  input  logic                  reset,
  ssd_scan_controller_if.slave  bus
);

  localparam int CW = (TICKS_PER_DIGIT > 1) ? $clog2(TICKS_PER_DIGIT) : 1;
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_TICKS - 1);
  localparam logic [CW-1:0] SHOW_LAST  = CW'(TICKS_PER_DIGIT - BLANK_TICKS - 1);

  ssd_state_e  state_q, state_d;
  digit_idx_t  idx_q, idx_d;
  logic        tc;
  logic        frame_end;
  logic [CW-1:0] term;

  logic [15:0] disp_q;
  logic [15:0] pend_q;
  logic        pend_valid_q;

  digit_idx_t  select_q;
  logic [3:0]  nibble_q;
  logic        digit_en_q;
  logic        load_ack_q;
  logic        frame_done_q;

  assign term = (state_q == ST_BLANK) ? BLANK_LAST : SHOW_LAST;

  // Every terminal count is a state change, so tc doubles as the restart.
  ssd_tick_counter #(.W(CW)) u_tick (
    .clk   (clk),
    .reset (reset),
    .clear (tc),
    .term  (term),
    .tc    (tc)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_BLANK;
      idx_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    frame_end = 1'b0;
    if (tc) begin
      case (state_q)
        ST_BLANK: state_d = ST_SHOW;
        ST_SHOW: begin
          state_d   = ST_BLANK;
          idx_d     = idx_q + 2'd1;
          frame_end = (idx_q == 2'd3);
        end
        default: state_d = ST_BLANK;
      endcase
    end
  end

  // Display update: pending is only consumed at the frame boundary, so a
  // frame never shows a mix of old and new digits. A load landing exactly on
  // the boundary goes straight to the display and supersedes any pending.
  always_ff @(posedge clk) begin
    if (reset) begin
      disp_q       <= 16'h0000;
      pend_q       <= 16'h0000;
      pend_valid_q <= 1'b0;
      load_ack_q   <= 1'b0;
    end else if (frame_end) begin
      pend_valid_q <= 1'b0;
      if (bus.load) begin
        disp_q     <= bus.value;
        load_ack_q <= 1'b1;
      end else if (pend_valid_q) begin
        disp_q     <= pend_q;
        load_ack_q <= 1'b1;
      end else begin
        load_ack_q <= 1'b0;
      end
    end else begin
      load_ack_q <= 1'b0;
      if (bus.load) begin
        pend_q       <= bus.value;
        pend_valid_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      select_q     <= 2'd0;
      nibble_q     <= 4'h0;
      digit_en_q   <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      select_q     <= idx_q;
      nibble_q     <= disp_q[{idx_q, 2'b00} +: 4];
      digit_en_q   <= (state_q == ST_SHOW) &&
                      !digit_blanked(disp_q, idx_q, bus.blank_lz);
      frame_done_q <= frame_end;
    end
  end

  assign bus.select     = select_q;
  assign bus.nibble     = nibble_q;
  assign bus.digit_en   = digit_en_q;
  assign bus.load_ack   = load_ack_q;
  assign bus.frame_done = frame_done_q;
  assign bus.dbg_state  = state_q;

endmodule

// File: tb/tb_ssd_scan_controller.sv
// tb_ssd_scan_controller -- frame-level bench for ssd_scan_controller with
// TICKS_PER_DIGIT = 8, BLANK_TICKS = 2. Each table row describes one 32-cycle
// frame: loads to drive, blank_lz, and what that frame must display.
module tb_ssd_scan_controller;
  import ssd_pkg::*;

  localparam int TPD = 8;
  localparam int BT  = 2;
  localparam int W   = 15;  // {changed, select, nibble, en_pattern[7:0]}

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  ssd_scan_controller_if bus();

  ssd_scan_controller #(
    .TICKS_PER_DIGIT (TPD),
    .BLANK_TICKS     (BT)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    int          ld0;      // frame cycle of first load, -1 = none
    logic [15:0] v0;
    int          ld1;      // frame cycle of second load, -1 = none
    logic [15:0] v1;
    logic        blz;
    logic [15:0] disp;     // value this frame must show
    logic [3:0]  en_mask;  // which slots light
    logic        ack;      // load_ack expected at this frame's end
  } vec_t;

  vec_t vecs[13];

  // ---------------- driver / monitor for one frame ----------------
  // Called at the negedge of the first internal cycle of a frame.
  task automatic run_frame(input int i);
    vec_t v;
    logic [W-1:0] word;
    logic [1:0]   sel_p0;
    logic [3:0]   nib_p0;
    logic [7:0]   en_pat;
    logic         chg;
    int           ack_cnt;
    int           fd_cnt;
    int           p;
    logic [15:0]  d;
    v = vecs[i];
    d = v.disp;
    for (int s = 0; s < 4; s++)
      exp_q.push_back({1'b0, 2'(s), d[4*s +: 4], v.en_mask[s] ? 8'hFC : 8'h00});
    ack_cnt = 0;
    fd_cnt  = 0;
    sel_p0  = '0;
    nib_p0  = '0;
    en_pat  = '0;
    chg     = 1'b0;
    for (int c = 0; c < 4*TPD; c++) begin
      bus.blank_lz = v.blz;
      if (c == v.ld0) begin
        bus.load = 1'b1; bus.value = v.v0;
      end else if (c == v.ld1) begin
        bus.load = 1'b1; bus.value = v.v1;
      end else begin
        bus.load = 1'b0;
      end
      @(negedge clk);
      p = c % TPD;
      if (p == 0) begin
        sel_p0 = bus.select; nib_p0 = bus.nibble; chg = 1'b0; en_pat = '0;
      end else if ((bus.select !== sel_p0) || (bus.nibble !== nib_p0)) begin
        chg = 1'b1;
      end
      en_pat[p] = bus.digit_en;
      if (bus.load_ack)   ack_cnt++;
      if (bus.frame_done) fd_cnt++;
      if (p == TPD - 1) begin
        word = exp_q.pop_front();
        check($sformatf("frame%0d slot%0d {chg,sel,nib,en}", i, c / TPD),
              32'({chg, sel_p0, nib_p0, en_pat}), 32'(word));
      end
    end
    check($sformatf("frame%0d load_ack at boundary", i), 32'(bus.load_ack), 32'(v.ack));
    check($sformatf("frame%0d load_ack count", i), ack_cnt, v.ack ? 1 : 0);
    check($sformatf("frame%0d frame_done at boundary", i), 32'(bus.frame_done), 1);
    check($sformatf("frame%0d frame_done count", i), fd_cnt, 1);
    bus.load = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " select"},     32'(bus.select),     0);
    check({tag, " nibble"},     32'(bus.nibble),     0);
    check({tag, " digit_en"},   32'(bus.digit_en),   0);
    check({tag, " load_ack"},   32'(bus.load_ack),   0);
    check({tag, " frame_done"}, 32'(bus.frame_done), 0);
    check({tag, " state"},      32'(bus.dbg_state),  32'(ST_BLANK));
  endtask

  // ---------------- test ----------------
  initial begin
    //            ld0 v0        ld1 v1        blz   disp      mask     ack
    vecs[0]  = '{-1, 16'h0000, -1, 16'h0000, 1'b0, 16'h0000, 4'b1111, 1'b0};
    vecs[1]  = '{-1, 16'h0000, -1, 16'h0000, 1'b1, 16'h0000, 4'b0001, 1'b0};
    vecs[2]  = '{10, 16'h12AB, -1, 16'h0000, 1'b0, 16'h0000, 4'b1111, 1'b1};
    vecs[3]  = '{-1, 16'h0000, -1, 16'h0000, 1'b1, 16'h12AB, 4'b1111, 1'b0};
    vecs[4]  = '{ 3, 16'h1111, 20, 16'h2222, 1'b0, 16'h12AB, 4'b1111, 1'b1};
    vecs[5]  = '{31, 16'h00F0, -1, 16'h0000, 1'b0, 16'h2222, 4'b1111, 1'b1};
    vecs[6]  = '{ 5, 16'h0005, -1, 16'h0000, 1'b1, 16'h00F0, 4'b0011, 1'b1};
    vecs[7]  = '{-1, 16'h0000, -1, 16'h0000, 1'b0, 16'h0005, 4'b1111, 1'b0};
    vecs[8]  = '{ 4, 16'h0AAA, 31, 16'h0BBB, 1'b1, 16'h0005, 4'b0001, 1'b1};
    vecs[9]  = '{-1, 16'h0000, -1, 16'h0000, 1'b1, 16'h0BBB, 4'b0111, 1'b0};
    vecs[10] = '{-1, 16'h0000, -1, 16'h0000, 1'b0, 16'h0BBB, 4'b1111, 1'b0};
    vecs[11] = '{-1, 16'h0000, -1, 16'h0000, 1'b0, 16'h0000, 4'b1111, 1'b0};
    vecs[12] = '{-1, 16'h0000, -1, 16'h0000, 1'b1, 16'h0000, 4'b0001, 1'b0};

    // Reset held with a load pending on the bus: load must be ignored.
    bus.value    = 16'hFFFF;
    bus.load     = 1'b1;
    bus.blank_lz = 1'b0;
    reset        = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    reset    = 1'b0;
    bus.load = 1'b0;

    for (int i = 0; i <= 10; i++) run_frame(i);

    // Load, then reset mid digit 1 with a coincident load.
    bus.value = 16'h3C3C;
    bus.load  = 1'b1;
    @(negedge clk);
    bus.load = 1'b0;
    repeat ($urandom_range(9, 12)) @(negedge clk);
    check("pre-reset select mid digit1", 32'(bus.select), 1);
    reset     = 1'b1;
    bus.load  = 1'b1;
    bus.value = 16'h7777;
    @(negedge clk);
    check_reset_outputs("mid-slot reset");
    reset    = 1'b0;
    bus.load = 1'b0;

    run_frame(11);
    run_frame(12);

    check("scoreboard drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

endmodule
